screen_sched: RTL and testbench

SCREEN_SCHED -- requirements
Module: screen_sched

---
 rtl/screen_pkg.sv | 30 +++
 rtl/screen_sched_if.sv | 23 ++
 rtl/screen_rr_arb.sv | 28 ++
 rtl/screen_sched.sv | 110 +++++++++++
 tb/tb_screen_sched.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/screen_pkg.sv
// Shared types and helpers for the screen frame scheduler.
package screen_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned FRAME_W = BYTE_W + 2;

    localparam logic [BYTE_W-1:0] CMD_PREFIX_DEFAULT = 8'hFE;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } schedState;

    // Serial word as the screen transmitter expects it, LSB first on the wire.
    typedef struct packed {
        logic              stopBit;
        logic [BYTE_W-1:0] data;
        logic              startBit;
    } frameWord;

    function automatic frameWord buildFrame(input logic [BYTE_W-1:0] dataByte);
        frameWord f;
        f.stopBit  = 1'b1;
        f.data     = dataByte;
        f.startBit = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/screen_sched_if.sv
// Requester and transmitter signals of the screen scheduler.
interface screen_sched_if;
    import screen_pkg::*;

    logic              cmd_valid;
    logic [BYTE_W-1:0] cmd_byte;
    logic              cmd_ready;
    logic              txt_valid;
    logic [BYTE_W-1:0] txt_byte;
    logic              txt_ready;
    frameWord          frame;
    logic              busy;

    modport master (
        output cmd_valid, cmd_byte, txt_valid, txt_byte,
        input  cmd_ready, txt_ready, frame, busy
    );

    modport slave (
        input  cmd_valid, cmd_byte, txt_valid, txt_byte,
        output cmd_ready, txt_ready, frame, busy
    );
endinterface

// File: rtl/screen_rr_arb.sv
// Two-way round-robin arbiter between command and text requesters.
module screen_rr_arb (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic cmdValid,
    input  logic txtValid,
    output logic cmdGrant_c,
    output logic txtGrant_c
);
    // Starts as "text granted last" so the command side wins the first tie.
    logic lastTxt;

    always_comb begin
        cmdGrant_c = enable && cmdValid && (!txtValid || lastTxt);
        txtGrant_c = enable && txtValid && !(cmdValid && lastTxt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lastTxt <= 1'b1;
        end else if (cmdGrant_c) begin
            lastTxt <= 1'b0;
        end else if (txtGrant_c) begin
            lastTxt <= 1'b1;
        end
    end
endmodule

// File: rtl/screen_sched.sv
// Schedules command and text bytes into fixed-length frame slots for the screen transmitter.
module screen_sched
    import screen_pkg::*;
#(
    parameter int unsigned       HOLD_CYC   = 4,
    parameter int unsigned       FRAME_CYC  = 50,
    parameter logic [BYTE_W-1:0] CMD_PREFIX = CMD_PREFIX_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    screen_sched_if.slave bus
);
    localparam int unsigned     CNT_W     = $clog2(FRAME_CYC);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(FRAME_CYC - 1);

    if (HOLD_CYC == 0 || FRAME_CYC <= HOLD_CYC) begin : gBadParams
        $error("screen_sched: need FRAME_CYC > HOLD_CYC > 0");
    end

    schedState         state, nextState;
    logic [CNT_W-1:0]  slotCnt, slotCntNext;
    frameWord          frameQ, frameNext;
    logic              busyQ;
    logic              pendCmd, pendCmdNext;
    logic [BYTE_W-1:0] cmdLatch, cmdLatchNext;
    logic              cmdGrant_c, txtGrant_c;

    screen_rr_arb uArb (
        .clk        (clk),
        .reset      (reset),
        .enable     ((state == IDLE) && !reset),
        .cmdValid   (bus.cmd_valid),
        .txtValid   (bus.txt_valid),
        .cmdGrant_c (cmdGrant_c),
        .txtGrant_c (txtGrant_c)
    );

    assign bus.cmd_ready = cmdGrant_c;
    assign bus.txt_ready = txtGrant_c;
    assign bus.frame     = frameQ;
    assign bus.busy      = busyQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            slotCnt  <= '0;
            frameQ   <= '0;
            busyQ    <= 1'b0;
            pendCmd  <= 1'b0;
            cmdLatch <= '0;
        end else begin
            state    <= nextState;
            slotCnt  <= slotCntNext;
            frameQ   <= frameNext;
            busyQ    <= (nextState != IDLE);
            pendCmd  <= pendCmdNext;
            cmdLatch <= cmdLatchNext;
        end
    end

    // Slot counter runs 0..FRAME_CYC-1 across SEND then GAP; the frame is built on entry to SEND.
    always_comb begin
        nextState    = state;
        slotCntNext  = slotCnt;
        frameNext    = frameQ;
        pendCmdNext  = pendCmd;
        cmdLatchNext = cmdLatch;
        unique case (state)
            IDLE: begin
                slotCntNext = '0;
                frameNext   = '0;
                if (cmdGrant_c) begin
                    nextState    = SEND;
                    frameNext    = buildFrame(CMD_PREFIX);
                    pendCmdNext  = 1'b1;
                    cmdLatchNext = bus.cmd_byte;
                end else if (txtGrant_c) begin
                    nextState = SEND;
                    frameNext = buildFrame(bus.txt_byte);
                end
            end
            SEND: begin
                slotCntNext = slotCnt + CNT_W'(1);
                if (slotCnt == HOLD_LAST) begin
                    nextState = GAP;
                    frameNext = '0;
                end
            end
            GAP: begin
                if (slotCnt == SLOT_LAST) begin
                    slotCntNext = '0;
                    if (pendCmd) begin
                        nextState   = SEND;
                        frameNext   = buildFrame(cmdLatch);
                        pendCmdNext = 1'b0;
                    end else begin
                        nextState = IDLE;
                    end
                end else begin
                    slotCntNext = slotCnt + CNT_W'(1);
                end
            end
            default: begin
                nextState = IDLE;
                frameNext = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_screen_sched.sv
// Randomized and directed checks of screen_sched against a queue-based slot model.
module tb_screen_sched;
    import screen_pkg::*;

    localparam int unsigned HOLD  = 4;
    localparam int unsigned FRAME = 50;
    localparam int unsigned GAPC  = FRAME - HOLD;
    localparam logic [7:0]  PREFIX = 8'hFE;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    screen_sched_if bus();

    screen_sched #(.HOLD_CYC(HOLD), .FRAME_CYC(FRAME), .CMD_PREFIX(PREFIX)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: queue of frame words for the cycles still to come in the current booking.
    logic [9:0] mq[$];
    logic [9:0] mFrame   = '0;
    logic       mBusy    = 1'b0;
    logic       mLastTxt = 1'b1;

    logic [12:0] obs;
    assign obs = {bus.cmd_ready, bus.txt_ready, bus.busy, bus.frame};

    function automatic logic [9:0] mk(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    function automatic logic [12:0] expObs();
        logic idle, cr, tr;
        idle = !mBusy && !reset;
        cr = idle && bus.cmd_valid && (!bus.txt_valid || mLastTxt);
        tr = idle && bus.txt_valid && !cr;
        return {cr, tr, mBusy, mFrame};
    endfunction

    task automatic pushSlot(input logic [9:0] f);
        repeat (HOLD) mq.push_back(f);
        repeat (GAPC) mq.push_back(10'b0);
    endtask

    // Advance one clock and the model with it; ends on the falling edge.
    task automatic step();
        logic [12:0] e;
        @(posedge clk);
        e = expObs();
        if (reset) begin
            mq.delete();
            mFrame = '0;
            mBusy = 1'b0;
            mLastTxt = 1'b1;
        end else begin
            if (e[12]) begin
                mLastTxt = 1'b0;
                pushSlot(mk(PREFIX));
                pushSlot(mk(bus.cmd_byte));
            end else if (e[11]) begin
                mLastTxt = 1'b1;
                pushSlot(mk(bus.txt_byte));
            end
            if (mq.size() > 0) begin
                mFrame = mq.pop_front();
                mBusy = 1'b1;
            end else begin
                mFrame = '0;
                mBusy = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic quiesce();
        bus.cmd_valid = 1'b0;
        bus.txt_valid = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 300 && mBusy; i++) step();
        step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            bus.cmd_valid = 1'($urandom);
            bus.txt_valid = 1'($urandom);
            bus.cmd_byte = 8'($urandom);
            bus.txt_byte = 8'($urandom);
            step();
            #1;
            total++;
            if (obs !== expObs()) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%h want=%h", i, obs, expObs());
            end
        end
        quiesce();
    endtask

    task automatic test_single_text();
        logic [9:0] want;
        bus.txt_byte = 8'h41;
        bus.txt_valid = 1'b1;
        #1;
        total++;
        if (obs !== expObs()) begin
            bad++;
            $display("FAIL text_accept got=%h want=%h", obs, expObs());
        end
        step();
        bus.txt_valid = 1'b0;
        for (int i = 1; i <= 55; i++) begin
            #1;
            want = (i <= HOLD) ? 10'b1_01000001_0 : 10'b0;
            total++;
            if (obs !== expObs() || bus.frame !== want || bus.busy !== (i <= FRAME)) begin
                bad++;
                $display("FAIL text cyc=%0d got=%h model=%h frame_want=%b", i, obs, expObs(), want);
            end
            step();
        end
    endtask

    task automatic test_single_cmd();
        logic [9:0] want;
        bus.cmd_byte = 8'h01;
        bus.cmd_valid = 1'b1;
        bus.txt_byte = 8'($urandom);
        bus.txt_valid = 1'b1;
        #1;
        total++;
        if (obs !== expObs() || bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL cmd_accept got=%h want=%h", obs, expObs());
        end
        step();
        bus.cmd_valid = 1'b0;
        for (int i = 1; i <= 2 * FRAME + 1; i++) begin
            #1;
            if (i <= HOLD) want = 10'b1_11111110_0;
            else if (i > FRAME && i <= FRAME + HOLD) want = 10'b1_00000001_0;
            else want = 10'b0;
            total++;
            if (obs !== expObs() || bus.frame !== want || bus.txt_ready !== (i > 2 * FRAME)) begin
                bad++;
                $display("FAIL cmd cyc=%0d got=%h model=%h frame_want=%b", i, obs, expObs(), want);
            end
            step();
        end
        quiesce();
    endtask

    task automatic test_tie();
        int grants[$];
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.txt_valid = 1'b1;
        for (int i = 0; i < 170; i++) begin
            bus.cmd_byte = 8'($urandom);
            bus.txt_byte = 8'($urandom);
            #1;
            if (bus.cmd_ready) grants.push_back(1);
            if (bus.txt_ready) grants.push_back(2);
            total++;
            if (obs !== expObs()) begin
                bad++;
                $display("FAIL tie cyc=%0d got=%h want=%h", i, obs, expObs());
            end
            step();
        end
        total++;
        if (grants.size() != 3 || grants[0] != 1 || grants[1] != 2 || grants[2] != 1) begin
            bad++;
            $display("FAIL tie_order got_count=%0d want=3 (cmd,txt,cmd)", grants.size());
        end
        quiesce();
    endtask

    task automatic test_latch();
        bus.txt_byte = 8'h41;
        bus.txt_valid = 1'b1;
        step();
        bus.txt_valid = 1'b0;
        bus.txt_byte = 8'h42;
        for (int i = 1; i <= HOLD + 2; i++) begin
            #1;
            total++;
            if (obs !== expObs() || (i <= HOLD && bus.frame.data !== 8'h41)) begin
                bad++;
                $display("FAIL latch cyc=%0d got=%h want=%h", i, obs, expObs());
            end
            step();
        end
        quiesce();
    endtask

    task automatic test_drop();
        int nz;
        nz = 0;
        bus.txt_byte = 8'($urandom);
        bus.txt_valid = 1'b1;
        step();
        bus.txt_valid = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 10) begin
                bus.txt_valid = 1'b1;
                bus.txt_byte = 8'h55;
            end else begin
                bus.txt_valid = 1'b0;
            end
            #1;
            if (bus.frame !== 10'b0) nz++;
            total++;
            if (obs !== expObs()) begin
                bad++;
                $display("FAIL drop cyc=%0d got=%h want=%h", i, obs, expObs());
            end
            step();
        end
        total++;
        if (nz != HOLD) begin
            bad++;
            $display("FAIL drop_frames got=%0d want=%0d", nz, HOLD);
        end
    endtask

    task automatic test_reset_mid_gap();
        bus.cmd_byte = 8'h5A;
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        repeat (20) step();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            total++;
            if (obs !== 13'b0 || obs !== expObs()) begin
                bad++;
                $display("FAIL rst_gap cyc=%0d got=%h want=0", i, obs);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 110; i++) begin
            step();
            #1;
            total++;
            if (obs !== 13'b0 || obs !== expObs()) begin
                bad++;
                $display("FAIL post_rst cyc=%0d got=%h want=0", i, obs);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2500; i++) begin
            bus.cmd_valid = ($urandom_range(0, 3) == 0);
            bus.txt_valid = ($urandom_range(0, 2) == 0);
            bus.cmd_byte = 8'($urandom);
            bus.txt_byte = 8'($urandom);
            reset = ($urandom_range(0, 399) == 0);
            #1;
            total++;
            if (obs !== expObs()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, obs, expObs());
            end
            step();
        end
        quiesce();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.txt_valid = 1'b0;
        bus.cmd_byte = '0;
        bus.txt_byte = '0;
        @(negedge clk);
        test_reset();
        test_single_text();
        test_single_cmd();
        test_tie();
        test_latch();
        test_drop();
        test_reset_mid_gap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
